// File: rtl/ray_sched_pkg.sv
// Shared types and helpers for the ray/object scheduler: FSM encoding, object
// record layout, the miss sentinel and the hit-acceptance test on IEEE doubles.
package ray_sched_pkg;

    localparam int DBL_W = 64;

    // +Inf: larger than every finite positive double, so it seeds the nearest-hit search.
    localparam logic [DBL_W-1:0] T_MISS = 64'h7FF0000000000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0][DBL_W-1:0] loc;
        logic [2:0][DBL_W-1:0] axis;
        logic                  is_cyl;
    } obj_rec_t;

    // Positive, finite and at least t_min; positive doubles order like unsigned integers.
    function automatic logic t_is_hit(input logic [DBL_W-1:0] t,
                                      input logic [DBL_W-1:0] t_min);
        return !t[DBL_W-1]
            && (t[DBL_W-2:DBL_W-12] != 11'h7FF)
            && (t[DBL_W-2:0] >= t_min[DBL_W-2:0]);
    endfunction

endpackage

// File: rtl/nearest_hit_reduce.sv
// Running minimum over tagged t beats: keeps the smallest accepted hit and its tag.
// A strictly-less update means equal t values keep the earlier (lower) tag.
module nearest_hit_reduce
    import ray_sched_pkg::*;
#(
    parameter int               SIZE  = 64,
    parameter int               OBJ_W = 4,
    parameter logic [SIZE-1:0]  T_MIN = 64'h3F50624DD2F1A9FC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             t_valid,
    input  logic [SIZE-1:0]  t_data,
    input  logic [OBJ_W-1:0] t_tag,
    output logic [SIZE-1:0]  best_t,
    output logic [OBJ_W-1:0] best_idx,
    output logic             hit
);

    logic take;

    always_comb begin
        take = t_valid
            && t_is_hit(t_data, T_MIN)
            && (t_data[SIZE-2:0] < best_t[SIZE-2:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_t   <= T_MISS;
            best_idx <= '0;
            hit      <= 1'b0;
        end else if (clear) begin
            best_t   <= T_MISS;
            best_idx <= '0;
            hit      <= 1'b0;
        end else if (take) begin
            best_t   <= t_data;
            best_idx <= t_tag;
            hit      <= 1'b1;
        end
    end

endmodule

// File: rtl/ray_obj_scheduler.sv
// Issues one ray against every active object through an external intersect unit and
// reduces the in-order t results to one nearest-hit record per ray.
// Optional RAY_SCHED_PERF_EN adds perf_rays/perf_hits/perf_stall counters.
module ray_obj_scheduler
    import ray_sched_pkg::*;
#(
    parameter int               SIZE    = 64,
    parameter int               MAX_OBJ = 16,
    parameter logic [SIZE-1:0]  T_MIN   = 64'h3F50624DD2F1A9FC,
    localparam int              OBJ_W   = $clog2(MAX_OBJ)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                cfg_wr_en,
    input  logic [OBJ_W-1:0]    cfg_wr_addr,
    input  logic [6*SIZE-1:0]   cfg_wr_obj,
    input  logic                cfg_wr_is_cyl,
    input  logic [OBJ_W:0]      cfg_num_obj,
    input  logic [6*SIZE-1:0]   ray_axis_tdata,
    input  logic                ray_axis_tvalid,
    output logic                ray_axis_tready,
    output logic [6*SIZE-1:0]   ix_ray_tdata,
    output logic [6*SIZE-1:0]   ix_obj_tdata,
    output logic                ix_obj_is_cyl,
    output logic                ix_tvalid,
    input  logic                ix_ray_tready,
    input  logic                ix_obj_tready,
    input  logic [SIZE-1:0]     ix_t_tdata,
    input  logic                ix_t_tvalid,
    output logic                ix_t_tready,
    output logic [SIZE-1:0]     hit_axis_tdata,
    output logic [OBJ_W-1:0]    hit_axis_obj,
    output logic                hit_axis_hit,
    output logic                hit_axis_tvalid,
    input  logic                hit_axis_tready,
    output logic                busy
`ifdef RAY_SCHED_PERF_EN
    ,
    output logic [31:0]         perf_rays,
    output logic [31:0]         perf_hits,
    output logic [31:0]         perf_stall
`endif
);

    localparam int CNT_W = OBJ_W + 1;

    state_t             state;
    logic               run;
    logic [CNT_W-1:0]   num;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   ret;
    logic [6*SIZE-1:0]  ray_q;
    logic [CNT_W-1:0]   num_clamped;
    logic               ray_hs;
    logic               issue;
    logic               t_beat;
    logic               out_hs;
    logic [OBJ_W-1:0]   idx_lo;
    obj_rec_t           obj_tab [MAX_OBJ];

    always_comb begin
        num_clamped = (cfg_num_obj > CNT_W'(MAX_OBJ)) ? CNT_W'(MAX_OBJ) : cfg_num_obj;
        ray_axis_tready = run && (state == IDLE);
        ray_hs  = ray_axis_tvalid && ray_axis_tready;
        ix_tvalid = (state == ISSUE);
        issue   = ix_tvalid && ix_ray_tready && ix_obj_tready;
        ix_t_tready = run;
        // Beats beyond the expected count cannot occur; the guard keeps ret bounded anyway.
        t_beat  = ix_t_tvalid && ix_t_tready
               && ((state == ISSUE) || (state == DRAIN))
               && (ret != num);
        hit_axis_tvalid = (state == OUTPUT);
        out_hs  = hit_axis_tvalid && hit_axis_tready;
        busy    = (state != IDLE);
        idx_lo  = idx[OBJ_W-1:0];
        ix_ray_tdata  = ray_q;
        ix_obj_tdata  = {obj_tab[idx_lo].axis, obj_tab[idx_lo].loc};
        ix_obj_is_cyl = obj_tab[idx_lo].is_cyl;
    end

    // Table has no reset; contents are only meaningful once written.
    always_ff @(posedge aclk) begin
        if (cfg_wr_en && !busy) begin
            obj_tab[cfg_wr_addr].loc    <= cfg_wr_obj[3*SIZE-1:0];
            obj_tab[cfg_wr_addr].axis   <= cfg_wr_obj[6*SIZE-1:3*SIZE];
            obj_tab[cfg_wr_addr].is_cyl <= cfg_wr_is_cyl;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            run   <= 1'b0;
            num   <= '0;
            idx   <= '0;
            ret   <= '0;
            ray_q <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    if (ray_hs) begin
                        ray_q <= ray_axis_tdata;
                        num   <= num_clamped;
                        idx   <= '0;
                        state <= (num_clamped == '0) ? OUTPUT : ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        idx <= idx + CNT_W'(1);
                        if (idx == num - CNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (ret == num) begin
                        state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (ray_hs) begin
                ret <= '0;
            end else if (t_beat) begin
                ret <= ret + CNT_W'(1);
            end
        end
    end

    nearest_hit_reduce #(
        .SIZE  (SIZE),
        .OBJ_W (OBJ_W),
        .T_MIN (T_MIN)
    ) u_reduce (
        .clk      (aclk),
        .rst_n    (aresetn),
        .clear    (ray_hs),
        .t_valid  (t_beat),
        .t_data   (ix_t_tdata),
        .t_tag    (ret[OBJ_W-1:0]),
        .best_t   (hit_axis_tdata),
        .best_idx (hit_axis_obj),
        .hit      (hit_axis_hit)
    );

`ifdef RAY_SCHED_PERF_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            perf_rays  <= '0;
            perf_hits  <= '0;
            perf_stall <= '0;
        end else begin
            if (out_hs) begin
                perf_rays <= perf_rays + 32'd1;
                if (hit_axis_hit) begin
                    perf_hits <= perf_hits + 32'd1;
                end
            end
            if (ix_tvalid && !issue) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
